universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the register width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit: operation enable; when low, all state holds.
REQ-005 The block SHALL have port mode, input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 The block SHALL have port sin_r, input, 1 bit: serial input entering the MSB on shift right.
REQ-007 The block SHALL have port sin_l, input, 1 bit: serial input entering the LSB on shift left.
REQ-008 The block SHALL have port pin, input, WIDTH bits: parallel load data.
REQ-009 The block SHALL have port pout, output, WIDTH bits: the register contents (registered).
REQ-010 The block SHALL have port sout_r, output, 1 bit: equal to pout[0] (combinational).
REQ-011 The block SHALL have port sout_l, output, 1 bit: equal to pout[WIDTH-1] (combinational).
REQ-012 The block SHALL have port bit_cnt, output, $clog2(WIDTH+1) bits: shifts accumulated in the current frame (registered).
REQ-013 The block SHALL have port frame_valid, output, 1 bit: registered one-cycle pulse marking a completed WIDTH-shift frame.

Function
REQ-014 On an edge with rst=0 and en=0, pout, bit_cnt SHALL hold and frame_valid SHALL be 0.
REQ-015 On an edge with en=1 and mode=00, pout, bit_cnt SHALL hold and frame_valid SHALL be 0.
REQ-016 On an edge with en=1 and mode=01, pout SHALL become {sin_r, pout[WIDTH-1:1]}.
REQ-017 On an edge with en=1 and mode=10, pout SHALL become {pout[WIDTH-2:0], sin_l}.
REQ-018 On an edge with en=1 and mode=11, pout SHALL become pin, bit_cnt SHALL become 0, and frame_valid SHALL be 0.
REQ-019 On each enabled shift (mode 01 or 10) with bit_cnt < WIDTH-1, bit_cnt SHALL increment by 1 and frame_valid SHALL be 0.
REQ-020 On an enabled shift with bit_cnt = WIDTH-1, bit_cnt SHALL wrap to 0 and frame_valid SHALL be 1 for exactly the following cycle.
REQ-021 Frames SHALL count left and right shifts identically; mixing directions within a frame is legal and counted.
REQ-022 Back-to-back frames SHALL produce frame_valid pulses exactly WIDTH enabled shifts apart, with no gap cycle required.
REQ-023 Latency SHALL be one clock: pout reflects sin_r/sin_l/pin on the edge that samples them.
REQ-024 Input changes between edges SHALL have no effect on pout, bit_cnt or frame_valid.

Reset
REQ-025 On an edge with rst=1, pout SHALL become 0, bit_cnt 0 and frame_valid 0, regardless of en and mode.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; the next frame_valid requires WIDTH further shifts after rst deasserts.
REQ-027 Before the first clock edge with rst=1, output values SHALL be undefined; the bench SHALL apply rst for at least one edge.

Verification (WIDTH=8)
REQ-028 rst=1 for 2 edges with mode=11, pin=8'hFF -> pout=8'h00, bit_cnt=0, frame_valid=0.
REQ-029 en=1, mode=01, sin_r sequence 1,0,1,1,0,0,0,0 on 8 edges -> pout=8'h0D, frame_valid=1 only in the cycle after edge 8, bit_cnt=0.
REQ-030 Same sequence on sin_l with mode=10 -> pout=8'hB0, sout_l=1, single frame_valid pulse.
REQ-031 mode=11, pin=8'hA5 after 3 shifts -> pout=8'hA5, bit_cnt=0; 8 further right shifts with sin_r=0 -> pout=8'h00, sout_r sequence 1,0,1,0,0,1,0,1, one frame_valid.
REQ-032 en toggled 0 on alternate edges during a 16-shift run -> pout/bit_cnt frozen while en=0; exactly 2 frame_valid pulses.
REQ-033 rst=1 after 5 shifts, then 8 shifts -> no frame_valid until the 8th post-reset shift.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with a shift counter that pulses frame_valid after every WIDTH shifts.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [1:0]                     mode,
  input  logic                           sin_r,
  input  logic                           sin_l,
  input  logic [WIDTH-1:0]               pin,
  output logic [WIDTH-1:0]               pout,
  output logic                           sout_r,
  output logic                           sout_l,
  output logic [$clog2(WIDTH+1)-1:0]     bit_cnt,
  output logic                           frame_valid
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  mode_e             mode_s;
  logic [WIDTH-1:0]  pout_q, pout_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              fv_q, fv_d;
  logic              shift_s;

  assign mode_s = mode_e'(mode);

  always_comb begin
    pout_d  = pout_q;
    cnt_d   = cnt_q;
    fv_d    = 1'b0;
    shift_s = 1'b0;
    if (en) begin
      unique case (mode_s)
        MODE_HOLD: ;
        MODE_SHR: begin
          pout_d  = {sin_r, pout_q[WIDTH-1:1]};
          shift_s = 1'b1;
        end
        MODE_SHL: begin
          pout_d  = {pout_q[WIDTH-2:0], sin_l};
          shift_s = 1'b1;
        end
        MODE_LOAD: begin
          pout_d = pin;
          cnt_d  = '0;
        end
        default: ;
      endcase
    end
    // Both shift directions advance the same frame counter.
    if (shift_s) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        fv_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pout_q <= '0;
      cnt_q  <= '0;
      fv_q   <= 1'b0;
    end else begin
      pout_q <= pout_d;
      cnt_q  <= cnt_d;
      fv_q   <= fv_d;
    end
  end

  assign pout        = pout_q;
  assign bit_cnt     = cnt_q;
  assign frame_valid = fv_q;
  assign sout_r      = pout_q[0];
  assign sout_l      = pout_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed and randomized check of universal_shift_reg (WIDTH=8) against a
// behavioural model that tracks the register as an integer and frames as
// a running shift total modulo WIDTH.
module tb_universal_shift_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst, en, sin_r, sin_l;
  logic [1:0]    mode;
  logic [W-1:0]  pin;
  logic [W-1:0]  pout;
  logic          sout_r, sout_l, frame_valid;
  logic [CW-1:0] bit_cnt;

  int n_vec = 0;
  int n_err = 0;
  int fv_seen = 0;

  // Reference model state
  int unsigned m_val;
  int unsigned m_shifts;
  bit          m_fv;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .pin(pin),
    .pout(pout), .sout_r(sout_r), .sout_l(sout_l),
    .bit_cnt(bit_cnt), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_val = 0; m_shifts = 0; m_fv = 0;
    end else begin
      m_fv = 0;
      if (en) begin
        case (mode)
          2'b01: begin
            m_val = (m_val / 2) + (sin_r ? (1 << (W - 1)) : 0);
            m_shifts++;
            m_fv = (m_shifts % W) == 0;
          end
          2'b10: begin
            m_val = ((m_val * 2) % (1 << W)) + sin_l;
            m_shifts++;
            m_fv = (m_shifts % W) == 0;
          end
          2'b11: begin
            m_val = pin; m_shifts = 0;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic sr, input logic sl, input logic [W-1:0] p);
    rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; pin = p;
    @(posedge clk);
    model_edge();
    #1;
    // Inputs wiggle between edges; the sampled state must not follow.
    sin_r = ~sr; sin_l = ~sl; pin = ~p;
    #1;
    if (frame_valid === 1'b1) fv_seen++;
    chk("pout",        64'(pout),        64'(m_val));
    chk("bit_cnt",     64'(bit_cnt),     64'(m_shifts % W));
    chk("frame_valid", 64'(frame_valid), 64'(m_fv));
    chk("sout_r",      64'(sout_r),      64'(m_val % 2));
    chk("sout_l",      64'(sout_l),      64'((m_val >> (W - 1)) % 2));
  endtask

  initial begin
    logic [7:0] seq;
    seq = 8'b0000_1101;  // bit i is the i-th serial bit: 1,0,1,1,0,0,0,0
    m_val = 0; m_shifts = 0; m_fv = 0;
    rst = 1'b1; en = 1'b1; mode = 2'b11; sin_r = 1'b0; sin_l = 1'b0; pin = 8'hFF;

    // Reset with load requested
    step(1, 1, 2'b11, 0, 0, 8'hFF);
    step(1, 1, 2'b11, 0, 0, 8'hFF);
    chk("rst_pout", 64'(pout), 64'h00);
    chk("rst_cnt",  64'(bit_cnt), 64'd0);

    // Right shift frame
    fv_seen = 0;
    for (int unsigned i = 0; i < 8; i++) step(0, 1, 2'b01, seq[i], 0, 8'h00);
    chk("shr_pout", 64'(pout), 64'h0D);
    chk("shr_fv_cnt", 64'(fv_seen), 64'd1);
    chk("shr_fv_last", 64'(frame_valid), 64'd1);
    step(0, 0, 2'b01, 0, 0, 8'h00);
    chk("shr_fv_drop", 64'(frame_valid), 64'd0);

    // Left shift frame
    step(1, 0, 2'b00, 0, 0, 8'h00);
    fv_seen = 0;
    for (int unsigned i = 0; i < 8; i++) step(0, 1, 2'b10, 0, seq[i], 8'h00);
    chk("shl_pout", 64'(pout), 64'hB0);
    chk("shl_soutl", 64'(sout_l), 64'd1);
    chk("shl_fv_cnt", 64'(fv_seen), 64'd1);

    // Load mid-frame, then shift the loaded value out
    for (int unsigned i = 0; i < 3; i++) step(0, 1, 2'b01, 1, 0, 8'h00);
    step(0, 1, 2'b11, 0, 0, 8'hA5);
    chk("ld_pout", 64'(pout), 64'hA5);
    chk("ld_cnt",  64'(bit_cnt), 64'd0);
    fv_seen = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      logic [7:0] a5;
      a5 = 8'hA5;
      chk("ld_soutr_seq", 64'(sout_r), 64'(a5[i]));
      step(0, 1, 2'b01, 0, 0, 8'h00);
    end
    chk("ld_drain", 64'(pout), 64'h00);
    chk("ld_fv_cnt", 64'(fv_seen), 64'd1);

    // Enable toggled on alternate edges across 16 shifts
    fv_seen = 0;
    for (int unsigned i = 0; i < 32; i++)
      step(0, (i % 2) == 0, 2'(1 + $urandom_range(0, 1)), 1'($urandom), 1'($urandom), 8'h00);
    chk("en_fv_cnt", 64'(fv_seen), 64'd2);

    // Reset mid-frame discards partial frame
    for (int unsigned i = 0; i < 5; i++) step(0, 1, 2'b01, 1, 0, 8'h00);
    step(1, 1, 2'b01, 1, 0, 8'h00);
    fv_seen = 0;
    for (int unsigned i = 0; i < 7; i++) step(0, 1, 2'b10, 0, 1, 8'h00);
    chk("rst_mid_nofv", 64'(fv_seen), 64'd0);
    step(0, 1, 2'b10, 0, 1, 8'h00);
    chk("rst_mid_fv", 64'(frame_valid), 64'd1);

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
           2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
